// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// state | meaning
// IDLE  | no transaction; arbitrate and accept one request
// ISSUE | mem_req_valid high, waiting for mem_req_ready
// WAIT  | request taken by memory, waiting for mem_resp_valid
// RESP  | one-cycle response pulse to the owning requester
module mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                protocol_err
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       owner_lsu;
    logic       grant_lsu;
    logic       grant_ifu;

    // LSU normally wins a contested cycle; IFU wins once it has lost LIMIT in a row.
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || starve_cnt != LIMIT);
        grant_ifu = ifu_req_valid && !grant_lsu;
    end

    assign ifu_req_ready = (state == IDLE) && grant_ifu;
    assign lsu_req_ready = (state == IDLE) && grant_lsu;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            owner_lsu      <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
            protocol_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            if (mem_resp_valid && state != WAIT) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        owner_lsu     <= 1'b1;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                        if (ifu_req_valid && starve_cnt != LIMIT) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_ifu) begin
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_wmask     <= '0;
                        owner_lsu     <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                        starve_cnt    <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // Stores also complete here: the response doubles as the write ack.
                    if (mem_resp_valid) begin
                        if (owner_lsu) begin
                            lsu_rdata      <= mem_rdata;
                            lsu_resp_valid <= 1'b1;
                        end else begin
                            ifu_rdata      <= mem_rdata;
                            ifu_resp_valid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: arbitration table, directed corner sequences, and a
// randomized run against a transaction-level scoreboard.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy, protocol_err;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit iv;
        bit lv;
        bit exp_ir;
        bit exp_lr;
    } arb_vec_t;

    arb_vec_t vecs[4];

    // transaction-level scoreboard state
    bit          outstanding, req_done, resp_due, mem_waiting;
    int          starve;
    string       grant_log;
    int          resp_count;
    bit          t_lsu, t_wen;
    logic [63:0] t_addr, t_wdata, t_rdata;
    logic [7:0]  t_wmask;
    int          ready_pct, resp_pct;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
        outstanding = 0; req_done = 0; resp_due = 0; mem_waiting = 0;
        starve = 0; grant_log = ""; resp_count = 0;
    endtask

    task automatic fetch_once(input logic [63:0] addr, input logic [63:0] data, input string tag);
        tick();
        ifu_req_valid = 1; ifu_addr = addr; mem_req_ready = 1;
        #1;
        check({tag, " ifu_ready"}, ifu_req_ready, 1);
        check({tag, " lsu_ready"}, lsu_req_ready, 0);
        tick();
        ifu_req_valid = 0;
        #1;
        check({tag, " req_valid"}, mem_req_valid, 1);
        check({tag, " addr"}, mem_addr, addr);
        check({tag, " wen"}, mem_wen, 0);
        check({tag, " wmask"}, mem_wmask, 0);
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = data;
        #1;
        check({tag, " wait busy"}, busy, 1);
        check({tag, " wait req_valid"}, mem_req_valid, 0);
        tick();
        mem_resp_valid = 0; mem_rdata = '0;
        #1;
        check({tag, " ifu_resp"}, ifu_resp_valid, 1);
        check({tag, " ifu_rdata"}, ifu_rdata, data);
        check({tag, " lsu_resp"}, lsu_resp_valid, 0);
        tick();
        #1;
        check({tag, " resp ends"}, ifu_resp_valid, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    // One cycle of scoreboard-checked traffic; memory side answers randomly.
    task automatic sb_cycle(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                            input bit lw, input logic [63:0] wd, input logic [7:0] wm);
        bit exp_i, exp_l, resp_now;
        tick();
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = wd; lsu_wmask = wm;
        mem_req_ready = ($urandom_range(99) < ready_pct);
        resp_now = 0;
        if (mem_waiting && $urandom_range(99) < resp_pct) begin
            mem_resp_valid = 1; mem_rdata = t_rdata; mem_waiting = 0; resp_now = 1;
        end else begin
            mem_resp_valid = 0; mem_rdata = {$urandom(), $urandom()};
        end
        #1;
        if (resp_due) begin
            check("sb ifu_resp", ifu_resp_valid, !t_lsu);
            check("sb lsu_resp", lsu_resp_valid, t_lsu);
            if (!t_lsu) check("sb ifu_rdata", ifu_rdata, t_rdata);
            else if (!t_wen) check("sb lsu_rdata", lsu_rdata, t_rdata);
            resp_count++;
        end else begin
            check("sb no ifu_resp", ifu_resp_valid, 0);
            check("sb no lsu_resp", lsu_resp_valid, 0);
        end
        exp_i = 0; exp_l = 0;
        if (!outstanding) begin
            if (lv && (!iv || starve != LIMIT)) exp_l = 1;
            else if (iv) exp_i = 1;
        end
        check("sb ifu_ready", ifu_req_ready, exp_i);
        check("sb lsu_ready", lsu_req_ready, exp_l);
        check("sb busy", busy, outstanding);
        check("sb mem_req_valid", mem_req_valid, outstanding && !req_done);
        check("sb protocol_err", protocol_err, 0);
        if (outstanding && !req_done && mem_req_ready) begin
            check("sb mem_addr", mem_addr, t_addr);
            check("sb mem_wen", mem_wen, t_wen);
            check("sb mem_wmask", mem_wmask, t_wmask);
            if (t_lsu) check("sb mem_wdata", mem_wdata, t_wdata);
            req_done = 1;
            mem_waiting = 1;
        end
        if (resp_due) begin
            outstanding = 0;
            resp_due = 0;
        end
        if (resp_now) resp_due = 1;
        if (exp_l || exp_i) begin
            t_lsu = exp_l;
            t_addr = exp_l ? la : ia;
            t_wen = exp_l ? lw : 1'b0;
            t_wmask = exp_l ? wm : 8'h00;
            t_wdata = wd;
            t_rdata = {$urandom(), $urandom()};
            outstanding = 1;
            req_done = 0;
            if (exp_i) starve = 0;
            else if (iv) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
            grant_log = {grant_log, exp_l ? "L" : "I"};
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_pct = 100; resp_pct = 100;
        while (outstanding && n < 50) begin
            sb_cycle(0, 0, '0, '0, 0, '0, '0);
            n++;
        end
        check("drain timeout", outstanding, 0);
    endtask

    initial begin
        vecs[0] = '{iv: 0, lv: 0, exp_ir: 0, exp_lr: 0};
        vecs[1] = '{iv: 1, lv: 0, exp_ir: 1, exp_lr: 0};
        vecs[2] = '{iv: 0, lv: 1, exp_ir: 0, exp_lr: 1};
        vecs[3] = '{iv: 1, lv: 1, exp_ir: 0, exp_lr: 1};

        // reset values, sampled while rst is held
        rst = 1;
        clear_inputs();
        tick();
        #1;
        check("rst busy", busy, 0);
        check("rst mem_req_valid", mem_req_valid, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst mem_wmask", mem_wmask, 0);
        check("rst mem_wen", mem_wen, 0);
        check("rst ifu_rdata", ifu_rdata, 0);
        check("rst lsu_rdata", lsu_rdata, 0);
        check("rst resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("rst protocol_err", protocol_err, 0);
        do_reset();

        // arbitration table, valids withdrawn before the edge so nothing is accepted
        for (int i = 0; i < 4; i++) begin
            tick();
            ifu_req_valid = vecs[i].iv; lsu_req_valid = vecs[i].lv;
            #1;
            check($sformatf("arb[%0d] ifu_ready", i), ifu_req_ready, vecs[i].exp_ir);
            check($sformatf("arb[%0d] lsu_ready", i), lsu_req_ready, vecs[i].exp_lr);
            #1;
            ifu_req_valid = 0; lsu_req_valid = 0;
        end

        fetch_once(64'h8000_0000, 64'h0010_0073_0000_0013, "fetch");

        // contention: LSU store first, IFU at N+4
        tick();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 64'h8000_1000; lsu_wen = 1;
        lsu_wdata = 64'h8765_4321_1234_5678; lsu_wmask = 8'h03; mem_req_ready = 1;
        #1;
        check("cont lsu_ready", lsu_req_ready, 1);
        check("cont ifu_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 0;
        #1;
        check("cont mem_addr", mem_addr, 64'h8000_1000);
        check("cont mem_wen", mem_wen, 1);
        check("cont mem_wmask", mem_wmask, 8'h03);
        check("cont mem_wdata", mem_wdata, 64'h8765_4321_1234_5678);
        tick();
        mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        #1;
        check("cont lsu_resp", lsu_resp_valid, 1);
        check("cont ifu_resp", ifu_resp_valid, 0);
        check("cont ifu_ready N+3", ifu_req_ready, 0);
        tick();
        #1;
        check("cont ifu_ready N+4", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0;
        #1;
        check("cont ifu mem_addr", mem_addr, 64'h8000_0004);
        check("cont starve_cnt", dut.starve_cnt, 0);
        tick();
        mem_resp_valid = 1; mem_rdata = 64'h1111;
        tick();
        mem_resp_valid = 0; mem_req_ready = 0;
        #1;
        check("cont ifu_resp", ifu_resp_valid, 1);
        tick();

        // memory stall in ISSUE
        tick();
        lsu_req_valid = 1; lsu_addr = 64'h2000; lsu_wen = 0; lsu_wdata = 64'hA5A5_0000_5A5A_FFFF;
        lsu_wmask = 8'hF0;
        #1;
        check("stall accept", lsu_req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            ifu_req_valid = 1; lsu_addr = 64'hFFFF_0000 + 64'(i); lsu_wdata = '0;
            #1;
            check("stall req_valid", mem_req_valid, 1);
            check("stall addr", mem_addr, 64'h2000);
            check("stall wdata", mem_wdata, 64'hA5A5_0000_5A5A_FFFF);
            check("stall readies", {ifu_req_ready, lsu_req_ready}, 0);
        end
        tick();
        ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
        #1;
        check("stall release", mem_req_valid, 1);
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'hCAFE_F00D_0000_0001;
        #1;
        check("stall wait", mem_req_valid, 0);
        tick();
        mem_resp_valid = 0;
        #1;
        check("stall lsu_resp", lsu_resp_valid, 1);
        check("stall lsu_rdata", lsu_rdata, 64'hCAFE_F00D_0000_0001);
        tick();
        #1;
        check("stall idle", busy, 0);

        // spurious response in IDLE
        tick();
        mem_resp_valid = 1; mem_rdata = 64'hDEAD_BEEF;
        #1;
        check("spur before", protocol_err, 0);
        tick();
        mem_resp_valid = 0;
        #1;
        check("spur err", protocol_err, 1);
        check("spur resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("spur idle", busy, 0);
        fetch_once(64'h8000_0100, 64'h0123_4567_89AB_CDEF, "spur fetch");
        check("spur sticky", protocol_err, 1);

        // reset during WAIT
        do_reset();
        tick();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0200; mem_req_ready = 1;
        tick();
        ifu_req_valid = 0;
        tick();
        mem_req_ready = 0;
        #1;
        check("rstmid in wait", busy && !mem_req_valid, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("rstmid busy", busy, 0);
        check("rstmid req_valid", mem_req_valid, 0);
        check("rstmid resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("rstmid protocol_err", protocol_err, 0);
        fetch_once(64'h8000_0300, 64'h5555_AAAA_5555_AAAA, "rstmid fetch");
        check("rstmid no err", protocol_err, 0);
        tick();
        mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        #1;
        check("late resp err", protocol_err, 1);

        // starvation guard with single-cycle memory
        do_reset();
        ready_pct = 100; resp_pct = 100;
        for (int n = 0; n < 200 && grant_log.len() < 10; n++) begin
            sb_cycle(1, 1, 64'h8000_0000 + 64'(4 * n), 64'h9000_0000 + 64'(8 * n), 0, '0, '0);
        end
        drain();
        tests++;
        if (grant_log != "LLLLILLLLI") begin
            fails++;
            $display("FAIL starve order: got %s expected LLLLILLLLI", grant_log);
        end
        check("starve resp count", resp_count, 10);

        // randomized traffic
        do_reset();
        ready_pct = 60; resp_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            sb_cycle($urandom_range(1), $urandom_range(1), {$urandom(), $urandom()},
                     {$urandom(), $urandom()}, 1'($urandom_range(1)), {$urandom(), $urandom()},
                     8'($urandom()));
        end
        drain();
        check("random completions", resp_count, grant_log.len());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single physical-memory port (the pmem DPI bridge) between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time from either requester and sequences it through a valid/ready request phase and a response phase on the memory side.
- Returns the response to the requester that issued it.
- Sits between the core front/back end and the memory model; replaces direct per-cycle pmem calls from the core.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; the byte mask is DATA_W/8 bits.
- STARVE_LIMIT, 4, consecutive contested LSU grants after which the IFU is forced priority (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid (one-cycle pulse)
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1=store, 0=load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte mask
- lsu_resp_valid  out  1  LSU completion (one-cycle pulse; carries load data)
- lsu_rdata  out  DATA_W  LSU load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  memory address
- mem_wen  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte mask
- mem_resp_valid  in  1  memory response / write acknowledge
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky: spurious memory response seen

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset state:
  - FSM goes to IDLE; starve_cnt=0.
  - All outputs are 0, including mem_addr, mem_wdata, mem_wmask, the rdata outputs and protocol_err.
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is ever outstanding.
- IDLE:
  - At most one of ifu_req_ready / lsu_req_ready is high. Ready is combinational: asserted for the grant winner when its valid is high.
  - On handshake, latch addr, wen, wdata, wmask and owner, then go to ISSUE.
  - For IFU transactions, wen=0 and wmask=0 are latched.
- ISSUE:
  - mem_req_valid=1; mem_addr/mem_wen/mem_wdata/mem_wmask come from the latches and stay stable.
  - On mem_req_ready=1, go to WAIT. Otherwise hold indefinitely.
- WAIT:
  - On mem_resp_valid=1, latch mem_rdata and go to RESP.
  - Stores also wait for mem_resp_valid, which acts as the write ack.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle, with rdata from the latch (don't-care for stores). The other requester's resp_valid stays 0.
  - Next state is IDLE. Responses cannot be back-pressured.
- Latency:
  - Accept in cycle N, mem_req_valid in N+1.
  - With ready and response each immediate: response pulse in N+3, next accept in N+4.
  - Minimum period is 4 cycles per transaction.
- Arbitration (evaluated in IDLE only):
  - Only one requester valid: it wins.
  - Both valid: LSU wins, unless starve_cnt==STARVE_LIMIT, in which case IFU wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when the LSU is granted while ifu_req_valid=1.
  - Clears to 0 when the IFU is granted.
  - Unchanged otherwise.
- Requesters may change or drop valid/addr while not accepted; the arbiter samples only at handshake.
- protocol_err: set when mem_resp_valid=1 in any state other than WAIT. The response is ignored and no resp_valid is generated. Cleared only by rst.
- mem_req_ready outside ISSUE is ignored.
- Reset mid-operation: the next edge returns to IDLE and the in-flight transaction is dropped with no requester response. A late mem_resp_valid after reset sets protocol_err.

Test Plan:
- Single fetch: ifu_addr=0x80000000 with mem_req_ready=1 and mem_resp_valid the cycle after issue, mem_rdata=0x0010007300000013 -> mem_req_valid at N+1 with mem_addr=0x80000000, mem_wen=0, mem_wmask=0x00; ifu_resp_valid pulses at N+3 with ifu_rdata=0x0010007300000013; lsu_resp_valid stays 0.
- Contention: IFU (0x80000004) and LSU store (0x80001000, wdata 0x8765432112345678, mask 0x03) both valid at N -> LSU accepted first (mem_wen=1, mem_wmask=0x03); IFU accepted at N+4; starve_cnt=0 afterwards.
- Starvation guard: both valid continuously, STARVE_LIMIT=4, single-cycle memory -> grant order L,L,L,L,I,L,L,L,L,I; exactly one resp pulse per transaction.
- Memory stall: mem_req_ready held 0 for 5 cycles in ISSUE -> mem_req_valid stays 1 with mem_addr/mem_wdata unchanged; both req_ready stay 0; transaction completes normally after ready rises.
- Spurious response: mem_resp_valid=1 in IDLE with data 0xDEADBEEF -> protocol_err=1 and remains 1; no ifu/lsu_resp_valid; subsequent transactions still complete.
- Reset mid-op: rst asserted for 1 cycle during WAIT -> next cycle busy=0, mem_req_valid=0, all resp_valid=0, protocol_err=0; a following IFU request completes normally.
